// File: rtl/sha_pad_ctrl.sv
// rtl/sha_pad_ctrl.sv - byte-serial SHA message padding sequencer (SHA_PAD_CTRL_LEN_LE_EN selects little-endian length)
module sha_pad_ctrl #(
    parameter int MAX_BYTES = 119
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       data_valid,
    input  logic       data_last,
    input  logic [7:0] data,
    output logic       data_ready,
    output logic       wr_en,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       padding_done,
    output logic       num_blocks,
    output logic [6:0] msg_len,
    output logic       len_err,
    input  logic       done_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PAD80,
        S_ZERO,
        S_LEN,
        S_DONE
    } state_t;

    localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

    state_t     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic [6:0] ptr_q, ptr_d;
    logic [6:0] msg_len_q, msg_len_d;
    logic       num_blocks_q, num_blocks_d;
    logic       len_err_q, len_err_d;
    logic       busy_q, busy_d;
    logic       padding_done_q, padding_done_d;

    logic       accept;
    logic [6:0] cnt_inc;
    logic [6:0] last_addr;
    logic [6:0] zero_end;
    logic [6:0] len_base;
    logic [2:0] len_idx;
    logic [9:0] bitlen;
    logic [7:0] len_byte;

    assign accept    = (state_q == S_LOAD) && data_valid && (cnt_q < MAX_CNT);
    assign cnt_inc   = cnt_q + 7'd1;
    assign last_addr = num_blocks_q ? 7'd127 : 7'd63;
    assign zero_end  = last_addr - 7'd8;
    assign len_base  = last_addr - 7'd7;
    assign len_idx   = 3'(ptr_q - len_base);
    assign bitlen    = {msg_len_q, 3'b000};

    // Only the two low-order bytes of the 64-bit length can be non-zero.
    always_comb begin
        len_byte = 8'h00;
`ifdef SHA_PAD_CTRL_LEN_LE_EN
        if (len_idx == 3'd0) len_byte = bitlen[7:0];
        if (len_idx == 3'd1) len_byte = {6'b0, bitlen[9:8]};
`else
        if (len_idx == 3'd6) len_byte = {6'b0, bitlen[9:8]};
        if (len_idx == 3'd7) len_byte = bitlen[7:0];
`endif
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        msg_len_d    = msg_len_q;
        num_blocks_d = num_blocks_q;
        len_err_d    = len_err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d     = 7'd0;
                    len_err_d = 1'b0;
                    if (data_last && !data_valid) begin
                        state_d      = S_PAD80;
                        msg_len_d    = 7'd0;
                        num_blocks_d = 1'b0;
                        ptr_d        = 7'd0;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (data_last || (cnt_inc == MAX_CNT)) begin
                        state_d      = S_PAD80;
                        msg_len_d    = cnt_inc;
                        num_blocks_d = (cnt_inc > 7'd55);
                        ptr_d        = cnt_inc;
                        len_err_d    = !data_last;
                    end
                end
            end
            S_PAD80: begin
                ptr_d   = ptr_q + 7'd1;
                state_d = (ptr_q < zero_end) ? S_ZERO : S_LEN;
            end
            S_ZERO: begin
                ptr_d = ptr_q + 7'd1;
                if (ptr_q == zero_end) state_d = S_LEN;
            end
            S_LEN: begin
                ptr_d = ptr_q + 7'd1;
                if (ptr_q == last_addr) state_d = S_DONE;
            end
            S_DONE: begin
                if (done_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d         = (state_d != S_IDLE);
        padding_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= 7'd0;
            ptr_q          <= 7'd0;
            msg_len_q      <= 7'd0;
            num_blocks_q   <= 1'b0;
            len_err_q      <= 1'b0;
            busy_q         <= 1'b0;
            padding_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ptr_q          <= ptr_d;
            msg_len_q      <= msg_len_d;
            num_blocks_q   <= num_blocks_d;
            len_err_q      <= len_err_d;
            busy_q         <= busy_d;
            padding_done_q <= padding_done_d;
        end
    end

    always_comb begin
        wr_en   = accept;
        wr_addr = ptr_q;
        wr_data = 8'h00;
        case (state_q)
            S_LOAD: begin
                wr_addr = cnt_q;
                wr_data = data;
            end
            S_PAD80: begin
                wr_en   = 1'b1;
                wr_data = 8'h80;
            end
            S_ZERO: wr_en = 1'b1;
            S_LEN: begin
                wr_en   = 1'b1;
                wr_data = len_byte;
            end
            default: ;
        endcase
    end

    assign data_ready   = (state_q == S_LOAD) && (cnt_q < MAX_CNT);
    assign busy         = busy_q;
    assign padding_done = padding_done_q;
    assign num_blocks   = num_blocks_q;
    assign msg_len      = msg_len_q;
    assign len_err      = len_err_q;

endmodule

// File: tb/tb_sha_pad_ctrl.sv
// tb/tb_sha_pad_ctrl.sv - randomized self-checking bench for sha_pad_ctrl
module tb_sha_pad_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       data_valid = 1'b0;
    logic       data_last = 1'b0;
    logic [7:0] data = 8'h00;
    logic       done_ack = 1'b0;
    logic       data_ready;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       padding_done;
    logic       num_blocks;
    logic [6:0] msg_len;
    logic       len_err;

    sha_pad_ctrl #(.MAX_BYTES(119)) dut (
        .clk(clk), .rst(rst), .start(start), .data_valid(data_valid),
        .data_last(data_last), .data(data), .data_ready(data_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .padding_done(padding_done), .num_blocks(num_blocks), .msg_len(msg_len),
        .len_err(len_err), .done_ack(done_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Behavioural buffer: records every write and whether each address was touched.
    logic [7:0] mem [128];
    bit         written [128];
    int         wr_cnt = 0;
    int         cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (start && !busy) begin
            for (int a = 0; a < 128; a++) begin
                mem[a]     <= 8'h5A;
                written[a] <= 1'b0;
            end
            wr_cnt <= 0;
        end else if (wr_en) begin
            mem[wr_addr]     <= wr_data;
            written[wr_addr] <= 1'b1;
            wr_cnt           <= wr_cnt + 1;
        end
    end

    logic [7:0] msg [128];

    int         e_n, e_last, e_lat;
    bit         e_err;
    int         r_acc, r_lat, r_bad_addr;
    bit         r_timeout, r_ready_seen;
    logic [7:0] r_bad_act, r_bad_exp;

    function automatic logic [7:0] exp_byte(input int a, input int n, input int last);
        longint unsigned bitlen;
        int k;
        bitlen = longint'(n) * 8;
        if (a < n) return msg[a];
        if (a == n) return 8'h80;
        if (a > last - 8) begin
            k = a - (last - 7);
`ifdef SHA_PAD_CTRL_LEN_LE_EN
            return 8'(bitlen >> (8 * k));
`else
            return 8'(bitlen >> (8 * (7 - k)));
`endif
        end
        return 8'h00;
    endfunction

    // Drives one message from IDLE to DONE and measures what the DUT did; leaves the DUT in DONE.
    task automatic run_msg(input int len, input bit with_last, input int gap_pct, input bit abc);
        int acc_edge, done_edge, i;
        logic [7:0] eb;
        for (int k = 0; k < 128; k++) msg[k] = 8'($urandom);
        if (abc) begin
            msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        end
        e_n    = (len > 119) ? 119 : len;
        e_err  = (len > 119) || (len == 119 && !with_last);
        e_last = (e_n > 55) ? 127 : 63;
        e_lat  = e_last - e_n + 1;

        @(negedge clk);
        start      = 1'b1;
        data_last  = (len == 0);
        data_valid = (len == 0) ? 1'b0 : 1'($urandom);
        data       = 8'($urandom);
        acc_edge   = cyc + 1;
        @(negedge clk);
        start        = 1'b0;
        i            = 0;
        done_edge    = -1;
        r_ready_seen = 1'b0;
        for (int b = 0; b < 600; b++) begin
            if (padding_done) begin
                done_edge = cyc;
                break;
            end
            if (i < len && int'($urandom_range(99)) >= gap_pct) begin
                data_valid = 1'b1;
                data       = msg[i];
                data_last  = with_last && (i == len - 1);
            end else begin
                data_valid = 1'b0;
                data       = 8'($urandom);
                data_last  = 1'($urandom);
            end
            if (data_ready) r_ready_seen = 1'b1;
            if (data_valid && data_ready) begin
                i++;
                acc_edge = cyc + 1;
            end
            @(negedge clk);
        end
        data_valid = 1'b0;
        data_last  = 1'b0;
        r_timeout  = (done_edge < 0);
        r_acc      = i;
        r_lat      = done_edge - acc_edge;
        r_bad_addr = -1;
        r_bad_act  = 8'h00;
        r_bad_exp  = 8'h00;
        for (int a = 0; a <= e_last; a++) begin
            eb = exp_byte(a, e_n, e_last);
            if (r_bad_addr < 0 && (!written[a] || mem[a] !== eb)) begin
                r_bad_addr = a;
                r_bad_act  = mem[a];
                r_bad_exp  = eb;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, padding_done, data_ready, wr_en, num_blocks, len_err, msg_len} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 0", {busy, padding_done, data_ready, wr_en, num_blocks, len_err, msg_len});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (wr_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: wr_en=%b busy=%b required 0 0", wr_en, busy);
        end
    endtask

    typedef struct {
        int len;
        bit with_last;
        int gap;
        bit abc;
    } case_t;

    task automatic test_padding;
        case_t cases[$];
        cases.push_back('{3, 1'b1, 0, 1'b1});
        cases.push_back('{55, 1'b1, 20, 1'b0});
        cases.push_back('{56, 1'b1, 20, 1'b0});
        cases.push_back('{0, 1'b1, 0, 1'b0});
        cases.push_back('{125, 1'b0, 10, 1'b0});
        cases.push_back('{119, 1'b1, 10, 1'b0});
        cases.push_back('{119, 1'b0, 0, 1'b0});
        cases.push_back('{120, 1'b1, 10, 1'b0});
        cases.push_back('{1, 1'b1, 30, 1'b0});
        for (int r = 0; r < 8; r++) cases.push_back('{int'($urandom_range(119, 1)), 1'b1, int'($urandom_range(40)), 1'b0});
        foreach (cases[c]) begin
            run_msg(cases[c].len, cases[c].with_last, cases[c].gap, cases[c].abc);
            n_checks++;
            if (r_timeout) begin
                n_fail++;
                $display("FAIL done_timeout len=%0d: padding_done never rose", cases[c].len);
            end
            n_checks++;
            if (r_lat != e_lat) begin
                n_fail++;
                $display("FAIL latency len=%0d: got %0d required %0d", cases[c].len, r_lat, e_lat);
            end
            n_checks++;
            if (r_acc != e_n) begin
                n_fail++;
                $display("FAIL accepted len=%0d: got %0d required %0d", cases[c].len, r_acc, e_n);
            end
            n_checks++;
            if (msg_len !== 7'(e_n) || num_blocks !== (e_n > 55) || len_err !== e_err) begin
                n_fail++;
                $display("FAIL status len=%0d: msg_len=%0d nb=%b err=%b required %0d %b %b",
                         cases[c].len, msg_len, num_blocks, len_err, e_n, e_n > 55, e_err);
            end
            n_checks++;
            if (busy !== 1'b1 || data_ready !== 1'b0 || wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL done_state len=%0d: busy=%b ready=%b wr_en=%b required 1 0 0", cases[c].len, busy, data_ready, wr_en);
            end
            n_checks++;
            if (wr_cnt != e_last + 1) begin
                n_fail++;
                $display("FAIL write_count len=%0d: got %0d required %0d", cases[c].len, wr_cnt, e_last + 1);
            end
            n_checks++;
            if (r_bad_addr >= 0) begin
                n_fail++;
                $display("FAIL buffer len=%0d: addr %0d got %h required %h", cases[c].len, r_bad_addr, r_bad_act, r_bad_exp);
            end
            if (cases[c].len == 0) begin
                n_checks++;
                if (r_ready_seen) begin
                    n_fail++;
                    $display("FAIL zero_len_ready: data_ready rose, required never");
                end
            end
            @(negedge clk);
            done_ack = 1'b1;
            @(negedge clk);
            done_ack = 1'b0;
            n_checks++;
            if (busy !== 1'b0 || padding_done !== 1'b0) begin
                n_fail++;
                $display("FAIL ack_release len=%0d: busy=%b done=%b required 0 0", cases[c].len, busy, padding_done);
            end
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            data_valid = 1'b1;
            data       = 8'h61 + 8'(k);
            data_last  = (k == 2);
            @(negedge clk);
        end
        data_valid = 1'b0;
        data_last  = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (wr_en !== 1'b1 || wr_data !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_zero_precond: wr_en=%b wr_data=%h required 1 00", wr_en, wr_data);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, padding_done, data_ready, wr_en, num_blocks, len_err, msg_len} !== 13'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %b required 0", {busy, padding_done, data_ready, wr_en, num_blocks, len_err, msg_len});
        end
        @(negedge clk);
        rst = 1'b0;
        run_msg(3, 1'b1, 0, 1'b1);
        n_checks++;
        if (r_timeout || r_lat != 61 || r_bad_addr >= 0 || msg_len !== 7'd3) begin
            n_fail++;
            $display("FAIL abc_after_reset: timeout=%b lat=%0d bad_addr=%0d msg_len=%0d required 0 61 -1 3",
                     r_timeout, r_lat, r_bad_addr, msg_len);
        end
    endtask

    task automatic test_done_handshake;
        int wc;
        @(negedge clk);
        n_checks++;
        if (padding_done !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake_precond: padding_done=%b required 1", padding_done);
        end
        start     = 1'b1;
        data_last = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        data_last = 1'b0;
        n_checks++;
        if (padding_done !== 1'b1 || busy !== 1'b1 || msg_len !== 7'd3) begin
            n_fail++;
            $display("FAIL start_in_done: done=%b busy=%b msg_len=%0d required 1 1 3", padding_done, busy, msg_len);
        end
        wc         = wr_cnt;
        data_valid = 1'b1;
        data       = 8'hEE;
        done_ack   = 1'b1;
        n_checks++;
        if (data_ready !== 1'b0 || wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_with_valid: ready=%b wr_en=%b required 0 0", data_ready, wr_en);
        end
        @(negedge clk);
        data_valid = 1'b0;
        done_ack   = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || padding_done !== 1'b0 || wr_cnt != wc || msg_len !== 7'd3 || len_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_release: busy=%b done=%b writes=%0d msg_len=%0d err=%b required 0 0 %0d 3 0",
                     busy, padding_done, wr_cnt - wc, msg_len, len_err, 0);
        end
    endtask

    initial begin
        test_reset;
        test_padding;
        test_reset_mid;
        test_done_handshake;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
